dp_rr_sched: RTL

- Round-robin scheduler that shares the single sub1->sub2 byte-array datapath (LANES x DW lanes, default 3 x 8 bit) between NUM_REQ requesters.
- Sits beside the top-level datapath. It arbitrates requests, muxes the winning requester's lane array onto the datapath input, issues a one-cycle start, then waits for done or timeout before releasing the grant.

---
 rtl/dp_rr_sched_pkg.sv | 19 +
 rtl/dp_rr_sched_rr_pick.sv | 40 ++++
 rtl/dp_rr_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dp_rr_sched_pkg.sv
// rtl/dp_rr_sched_pkg.sv - shared types and default parameters for the round-robin datapath scheduler
package dp_rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int NUM_REQ_DEF = 3;
  localparam int LANES_DEF   = 3;
  localparam int DW_DEF      = 8;
  localparam int TMO_CYC_DEF = 15;

  // One requester's lane array at the default geometry
  typedef logic [LANES_DEF-1:0][DW_DEF-1:0] lane_arr_t;

endpackage

// File: rtl/dp_rr_sched_rr_pick.sv
// rtl/dp_rr_sched_rr_pick.sv - combinational round-robin priority picker
module rr_pick
  import dp_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       any
);

  localparam int SW = $clog2(NUM_REQ);

  // one extra bit so ptr+i never overflows before the wrap compare
  logic [SW:0] idx;

  // scan upward from ptr, wrapping past NUM_REQ-1 back to 0; first set req wins
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (SW+1)'(i);
      if (idx >= (SW+1)'(NUM_REQ)) begin
        idx = idx - (SW+1)'(NUM_REQ);
      end
      if (!any && req[idx[SW-1:0]]) begin
        any     = 1'b1;
        win_idx = idx[SW-1:0];
      end
    end
    if (any) begin
      win_oh[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dp_rr_sched.sv
// rtl/dp_rr_sched.sv - round-robin owner of the shared lane datapath; DP_RR_SCHED_STATS_EN adds grant/timeout counters
module dp_rr_sched
  import dp_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int DW      = DW_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ-1:0][LANES-1:0][DW-1:0] req_data,
  output logic [NUM_REQ-1:0]                    gnt,
  output logic [LANES-1:0][DW-1:0]              dp_data,
  output logic                                  dp_start,
  input  logic                                  dp_done,
  output logic [$clog2(NUM_REQ)-1:0]            dp_sel,
  output logic                                  busy,
  output logic                                  tmo_err
`ifdef DP_RR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]              gnt_cnt,
  output logic [7:0]                            tmo_cnt
`endif
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TMO_CYC + 1);

  state_t                   state_q, state_d;
  logic [SW-1:0]            sel_q, sel_d;
  logic [SW-1:0]            ptr_q, ptr_d, ptr_nxt;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [LANES-1:0][DW-1:0] data_q, data_d;
  logic                     tmo_q, tmo_d;
  logic                     tmo_evt;

  logic [NUM_REQ-1:0]       win_oh;
  logic [SW-1:0]            win_idx;
  logic                     win_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // next-state, owner latch, lane mux and WAIT-phase timeout counter
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    tmo_evt = 1'b0;
    cnt_inc = (cnt_q == CW'(TMO_CYC)) ? cnt_q : cnt_q + 1'b1;
    ptr_nxt = (sel_q == SW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|req) state_d = GRANT;
      end
      GRANT: begin
        // requesters hold req until granted, so win_any only drops on misuse
        if (win_any) begin
          sel_d = win_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) data_d = req_data[i];
          end
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // done wins a tie with the final timeout cycle
        if (dp_done) begin
          state_d = IDLE;
          ptr_d   = ptr_nxt;
        end else if (cnt_inc == CW'(TMO_CYC)) begin
          state_d = IDLE;
          ptr_d   = ptr_nxt;
          tmo_d   = 1'b1;
          tmo_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  // grant pulse coincides with the start strobe
  always_comb begin
    gnt = '0;
    if (state_q == START) gnt[sel_q] = 1'b1;
  end

  assign dp_start = (state_q == START);
  assign busy     = (state_q != IDLE);
  assign dp_sel   = sel_q;
  assign dp_data  = data_q;
  assign tmo_err  = tmo_q;

`ifdef DP_RR_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] gcnt_q, gcnt_d;
  logic [7:0]               tcnt_q, tcnt_d;

  // saturating per-requester grant and global timeout counters
  always_comb begin
    gcnt_d = gcnt_q;
    tcnt_d = tcnt_q;
    if (state_q == START && gcnt_q[sel_q] != 16'hFFFF) begin
      gcnt_d[sel_q] = gcnt_q[sel_q] + 16'd1;
    end
    if (tmo_evt && tcnt_q != 8'hFF) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign gnt_cnt = gcnt_q;
  assign tmo_cnt = tcnt_q;
`endif

endmodule
